// File: rtl/dm_bridge_pkg.sv
// Shared encodings for the dm_bridge load/store unit: access sizes, FSM states, default depth.
package dm_bridge_pkg;
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam int DM_WORDS_DEFAULT = 4096;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_WR,
    S_RSP,
    S_ERR
  } state_e;
endpackage

// File: rtl/dm_bridge_if.sv
// CPU-side request/response bus of dm_bridge; master = CPU memory stage, slave = bridge.
interface dm_bridge_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );
  modport slave (
    input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dm_lane_align.sv
// Combinational lane logic: load extract/extend and sub-word store merge (little-endian).
module dm_lane_align
  import dm_bridge_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        sgn,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic [31:0] st_word
);
  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v = word[8*addr_lo +: 8];
    half_v = addr_lo[1] ? word[31:16] : word[15:0];
    case (size)
      SZ_BYTE: rdata = {{24{sgn & byte_v[7]}}, byte_v};
      SZ_HALF: rdata = {{16{sgn & half_v[15]}}, half_v};
      default: rdata = word;
    endcase
  end

  // Each byte lane either keeps the old memory byte or takes the matching byte of wdata.
  for (genvar k = 0; k < 4; k++) begin : g_lane
    localparam logic [1:0] LANE = 2'(k);
    logic       en;
    logic [1:0] src;
    always_comb begin
      en  = (size == SZ_WORD) ||
            (size == SZ_HALF && addr_lo[1] == LANE[1]) ||
            (size == SZ_BYTE && addr_lo == LANE);
      src = (size == SZ_WORD) ? LANE : (size == SZ_HALF) ? {1'b0, LANE[0]} : 2'b00;
    end
    assign st_word[8*k +: 8] = en ? wdata[8*src +: 8] : word[8*k +: 8];
  end
endmodule

// File: rtl/dm_bridge.sv
// Load/store bridge between the CPU memory stage and a synchronous-read word memory.
// Optional: DM_BRIDGE_ALIGN_CHECK_EN rejects misaligned half/word accesses instead of aligning them.
module dm_bridge
  import dm_bridge_pkg::*;
#(
  parameter int DEPTH_WORDS = DM_WORDS_DEFAULT
) (
  input  logic         clka,
  input  logic         rsta_n,
  dm_bridge_if.slave   bus,
  output logic [3:0]   mem_wea,
  output logic [31:0]  mem_addra,
  output logic [31:0]  mem_dina,
  input  logic [31:0]  mem_douta
);
  state_e      state, state_nx;
  logic        r_we, r_sgn;
  logic [1:0]  r_size;
  logic [31:0] r_addr, r_wdata;

  logic        accept, err_in, mis_in, range_bad;
  logic [31:0] addr_in;
  logic [31:0] ld_data, st_word;

  assign accept    = bus.req_valid && (state == S_IDLE);
  assign range_bad = {2'b00, bus.req_addr[31:2]} >= 32'(DEPTH_WORDS);

`ifdef DM_BRIDGE_ALIGN_CHECK_EN
  always_comb begin
    mis_in  = (bus.req_size == SZ_HALF && bus.req_addr[0]) ||
              (bus.req_size == SZ_WORD && bus.req_addr[1:0] != 2'b00);
    addr_in = bus.req_addr;
  end
`else
  // Misaligned low bits are snapped to the natural alignment of the access.
  always_comb begin
    mis_in  = 1'b0;
    addr_in = bus.req_addr;
    if (bus.req_size == SZ_HALF) addr_in[0]   = 1'b0;
    if (bus.req_size == SZ_WORD) addr_in[1:0] = 2'b00;
  end
`endif

  assign err_in = (bus.req_size == 2'b11) || range_bad || mis_in;

  always_ff @(posedge clka or negedge rsta_n) begin
    if (!rsta_n) begin
      state   <= S_IDLE;
      r_we    <= 1'b0;
      r_sgn   <= 1'b0;
      r_size  <= 2'b00;
      r_addr  <= '0;
      r_wdata <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        r_we    <= bus.req_we;
        r_sgn   <= bus.req_signed;
        r_size  <= bus.req_size;
        r_addr  <= addr_in;
        r_wdata <= bus.req_wdata;
      end
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (accept) begin
        if (err_in)                       state_nx = S_ERR;
        else if (!bus.req_we)             state_nx = S_RD;
        else if (bus.req_size == SZ_WORD) state_nx = S_WR;
        else                              state_nx = S_RD;
      end
      S_RD:    state_nx = r_we ? S_WR : S_RSP;
      S_WR:    state_nx = S_RSP;
      S_RSP:   state_nx = S_IDLE;
      S_ERR:   state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  dm_lane_align u_align (
    .size    (r_size),
    .sgn     (r_sgn),
    .addr_lo (r_addr[1:0]),
    .word    (mem_douta),
    .wdata   (r_wdata),
    .rdata   (ld_data),
    .st_word (st_word)
  );

  // Write enable decodes straight from state so an async reset kills it immediately.
  always_comb begin
    bus.req_ready = (state == S_IDLE);
    bus.rsp_valid = (state == S_RSP) || (state == S_ERR);
    bus.rsp_err   = (state == S_ERR);
    bus.rsp_rdata = (state == S_RSP && !r_we) ? ld_data : 32'h0;
    mem_wea       = (state == S_WR) ? 4'hF : 4'h0;
    mem_addra     = {2'b00, r_addr[31:2]};
    mem_dina      = (state == S_WR) ? st_word : r_wdata;
  end
endmodule

// File: tb/tb_dm_bridge.sv
// Self-checking bench for dm_bridge: directed test-plan steps plus random traffic against a byte-array model.
module tb_dm_bridge;
  import dm_bridge_pkg::*;

  localparam int DW = 4096;

  logic        clka = 1'b0;
  logic        rsta_n = 1'b0;
  logic [3:0]  mem_wea;
  logic [31:0] mem_addra, mem_dina, mem_douta;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem   [0:DW-1];
  logic [7:0]  ref_b [0:4*DW-1];

  dm_bridge_if bif ();

  dm_bridge #(.DEPTH_WORDS(DW)) dut (
    .clka      (clka),
    .rsta_n    (rsta_n),
    .bus       (bif.slave),
    .mem_wea   (mem_wea),
    .mem_addra (mem_addra),
    .mem_dina  (mem_dina),
    .mem_douta (mem_douta)
  );

  always #5 clka = ~clka;

  // Synchronous-read memory: whole-word write whenever any enable bit is set.
  always @(posedge clka) begin
    if (mem_addra < DW) begin
      if (mem_wea != 4'h0) mem[mem_addra[11:0]] <= mem_dina;
      mem_douta <= mem[mem_addra[11:0]];
    end else begin
      mem_douta <= 32'h0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model: byte-addressed memory, behaviour taken straight from the access rules.
  task automatic model(input logic we, input logic [1:0] sz, input logic sgn,
                       input logic [31:0] addr_i, input logic [31:0] wd,
                       output logic e_err, output logic [31:0] e_rd, output int e_lat);
    int n;
    logic [31:0] a, v;
    n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    a = addr_i;
    e_err = (sz == 2'd3) || ((a / 4) >= DW);
    if (!e_err && (a % n) != 0) begin
`ifdef DM_BRIDGE_ALIGN_CHECK_EN
      e_err = 1'b1;
`else
      a = a - (a % n);
`endif
    end
    e_rd = 32'h0;
    if (e_err) begin
      e_lat = 1;
    end else if (we) begin
      for (int i = 0; i < n; i++) ref_b[a + i] = 8'(wd >> (8 * i));
      e_lat = (n == 4) ? 2 : 3;
    end else begin
      v = 32'h0;
      for (int i = 0; i < n; i++) v = v | (32'(ref_b[a + i]) << (8 * i));
      if (sgn && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
      e_rd  = v;
      e_lat = 2;
    end
  endtask

  function automatic logic [31:0] ref_word(input int idx);
    return {ref_b[4*idx+3], ref_b[4*idx+2], ref_b[4*idx+1], ref_b[4*idx]};
  endfunction

  task automatic issue(input logic we, input logic [1:0] sz, input logic sgn,
                       input logic [31:0] addr, input logic [31:0] wd, input string tag);
    logic e_err, wrote, got;
    logic [31:0] e_rd, rd;
    logic r_err;
    int e_lat, lat;
    @(negedge clka);
    chk({tag, ":ready"}, 32'(bif.req_ready), 32'd1);
    bif.req_valid  = 1'b1;
    bif.req_we     = we;
    bif.req_size   = sz;
    bif.req_signed = sgn;
    bif.req_addr   = addr;
    bif.req_wdata  = wd;
    @(posedge clka);
    #1 bif.req_valid = 1'b0;
    model(we, sz, sgn, addr, wd, e_err, e_rd, e_lat);
    lat = 0; wrote = 1'b0; got = 1'b0; rd = 32'h0; r_err = 1'b0;
    while (!got && lat < 8) begin
      @(negedge clka);
      lat++;
      if (mem_wea != 4'h0) wrote = 1'b1;
      if (bif.rsp_valid) begin
        got = 1'b1; rd = bif.rsp_rdata; r_err = bif.rsp_err;
      end
    end
    chk({tag, ":lat"},   32'(lat),   32'(e_lat));
    chk({tag, ":err"},   32'(r_err), 32'(e_err));
    chk({tag, ":rdata"}, rd,         e_rd);
    chk({tag, ":wrote"}, 32'(wrote), 32'(we && !e_err));
  endtask

  initial begin
    for (int i = 0; i < DW; i++) mem[i] = 32'h0;
    for (int i = 0; i < 4 * DW; i++) ref_b[i] = 8'h0;
    bif.req_valid = 1'b0; bif.req_we = 1'b0; bif.req_size = 2'b00;
    bif.req_signed = 1'b0; bif.req_addr = 32'h0; bif.req_wdata = 32'h0;

    #3;
    chk("rst:ready", 32'(bif.req_ready), 32'd1);
    chk("rst:rsp_valid", 32'(bif.rsp_valid), 32'd0);
    chk("rst:rsp_err", 32'(bif.rsp_err), 32'd0);
    chk("rst:rdata", bif.rsp_rdata, 32'h0);
    chk("rst:wea", 32'(mem_wea), 32'd0);
    chk("rst:addra", mem_addra, 32'h0);
    chk("rst:dina", mem_dina, 32'h0);
    #20 rsta_n = 1'b1;

    issue(1, SZ_WORD, 0, 32'h10, 32'hDEAD_BEEF, "st_w");
    issue(0, SZ_WORD, 0, 32'h10, 32'h0, "ld_w");
    issue(1, SZ_WORD, 0, 32'h10, 32'h1122_3344, "st_w2");
    issue(1, SZ_BYTE, 0, 32'h11, 32'h0000_00AA, "st_b");
    issue(0, SZ_WORD, 0, 32'h10, 32'h0, "ld_w_b");
    issue(0, SZ_BYTE, 1, 32'h11, 32'h0, "ld_bs");
    issue(0, SZ_BYTE, 0, 32'h11, 32'h0, "ld_bu");
    issue(1, SZ_WORD, 0, 32'h10, 32'h0, "st_w0");
    issue(1, SZ_HALF, 0, 32'h12, 32'h0000_8001, "st_h");
    issue(0, SZ_HALF, 1, 32'h12, 32'h0, "ld_hs");
    issue(0, SZ_WORD, 0, 32'h10, 32'h0, "ld_w_h");
    issue(0, SZ_WORD, 0, 32'h4000, 32'h0, "ld_oor");
    issue(1, SZ_WORD, 0, 32'h4000, 32'h1234_5678, "st_oor");
    issue(0, 2'b11, 0, 32'h20, 32'h0, "ld_sz3");
    issue(0, SZ_HALF, 1, 32'h13, 32'h0, "ld_h_mis");
    issue(1, SZ_HALF, 0, 32'h17, 32'h0000_5A5A, "st_h_mis");
    issue(0, SZ_WORD, 0, 32'h14, 32'h0, "ld_w_mis");

    // Reset in the WR cycle of a sub-word store: request dropped, word untouched.
    issue(1, SZ_WORD, 0, 32'h30, 32'hCAFE_F00D, "pre_rst");
    @(negedge clka);
    bif.req_valid = 1'b1; bif.req_we = 1'b1; bif.req_size = SZ_BYTE;
    bif.req_signed = 1'b0; bif.req_addr = 32'h31; bif.req_wdata = 32'h0000_0077;
    @(posedge clka);
    #1 bif.req_valid = 1'b0;
    @(negedge clka);
    @(negedge clka);
    chk("mid:wea_in_wr", 32'(mem_wea), 32'hF);
    rsta_n = 1'b0;
    #1;
    chk("mid:wea_async", 32'(mem_wea), 32'd0);
    chk("mid:ready", 32'(bif.req_ready), 32'd1);
    @(posedge clka);
    #1;
    chk("mid:mem_word", mem[12], ref_word(12));
    rsta_n = 1'b1;
    begin
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < 4; i++) begin
        @(negedge clka);
        if (bif.rsp_valid) seen = 1'b1;
      end
      chk("mid:no_rsp", 32'(seen), 32'd0);
    end
    issue(0, SZ_WORD, 0, 32'h30, 32'h0, "post_rst_ld");

    for (int it = 0; it < 300; it++) begin
      logic [31:0] a;
      a = ($urandom_range(0, 15) == 0) ? 32'h4000 + 32'($urandom_range(0, 63))
                                       : 32'($urandom_range(0, 63));
      issue(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            a, $urandom, "rnd");
    end
    for (int w = 0; w < 16; w++) chk("final_mem", mem[w], ref_word(w));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    errors++;
    $display("FAIL timeout observed=running expected=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/dm_bridge.md
# dm_bridge

Load/store access unit between the CPU memory stage and the synchronous-read data memory. It accepts byte/half/word requests at byte addresses and converts them to word-indexed memory accesses. It aligns and sign-extends load data, and performs read-modify-write for sub-word stores, because the data memory writes a whole word whenever any `wea` bit is set. Responses come back after a fixed per-type latency. Only one request is outstanding at a time.

## Interface
- `DEPTH_WORDS`, 4096: memory depth in words; word index ≥ this is out of range.
- `clka` in 1: clock; every state change happens on the rising edge.
- `rsta_n` in 1: asynchronous active-low reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: bridge can accept a request; the request is taken when `req_valid & req_ready`.
- `req_we` in 1: 1 = store, 0 = load.
- `req_size` in 2: 00 = byte, 01 = half, 10 = word; 11 is illegal and returns an error.
- `req_signed` in 1: load sign-extends when 1, zero-extends when 0.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data, right-justified.
- `rsp_valid` out 1: one-cycle response pulse; there is no back-pressure.
- `rsp_rdata` out 32: load result; 0 for stores and errors.
- `rsp_err` out 1: request rejected; no memory write occurred.
- `mem_wea` out 4: memory write enable; nonzero means write the whole word.
- `mem_addra` out 32: word index, `req_addr[31:2]` zero-extended.
- `mem_dina` out 32: full word to write.
- `mem_douta` in 32: memory read data, valid one cycle after the address is sampled.

## Operation
- States: IDLE, RD, WR, RSP, ERR.
- `req_ready` = 1 in IDLE, 0 otherwise. On accept, the request is latched into internal registers.
- Transitions out of IDLE on accept:
  - error → ERR
  - load → RD
  - word store → WR
  - byte/half store → RD
- RD: drive `mem_addra`, `mem_wea` = 0. Next state: WR if the request is a store, RSP if it is a load.
- WR: drive `mem_wea` = 4'hF.
  - `mem_dina` = `req_wdata` for word stores.
  - For sub-word stores, `mem_dina` = `mem_douta` with the addressed lane(s) replaced by the low byte/half of `req_wdata`.
  - Next state: RSP.
- RSP: `rsp_valid` = 1, `rsp_err` = 0.
  - For loads, `rsp_rdata` is extracted combinationally from `mem_douta`.
  - Next state: IDLE.
- ERR: `rsp_valid` = 1, `rsp_err` = 1, `rsp_rdata` = 0. Next state: IDLE.
- Errors: `req_size` = 11, or word index ≥ `DEPTH_WORDS`. Misalignment is an error only when the check is compiled in (see Configuration).
- Lane rules (little-endian):
  - Byte lane k = `addr[1:0]` occupies bits 8k+7:8k.
  - Half lane = `addr[1]`, occupying bits 15:0 or 31:16.
- Extension: the extracted byte or half is sign-extended from its top bit when `req_signed` = 1, otherwise zero-extended. Word loads ignore `req_signed`.
- Outside RD and WR, `mem_wea` = 0. `mem_addra` and `mem_dina` hold the latched values; they are don't-care but must be stable.

## Timing
- Reset (asynchronous): state = IDLE and all latched registers are cleared. Outputs are then: `req_ready` = 1; `rsp_valid`, `rsp_err`, `rsp_rdata`, `mem_wea`, `mem_addra`, `mem_dina` = 0.
- Reset mid-operation: the in-flight request is dropped with no response. `mem_wea` falls to 0 immediately, without waiting for a clock edge.
- Latency, counted in cycles after the accept cycle:
  - load: `rsp_valid` in cycle 2
  - word store: cycle 2
  - sub-word store: cycle 3
  - error: cycle 1
- Memory write takes effect at the rising edge that ends WR.
- A load issued after a store sees the stored data; there is no hazard, because the store completes before IDLE.
- Back-to-back requests: the next accept occurs in the cycle after RSP/ERR.

## Configuration
- `DM_BRIDGE_ALIGN_CHECK_EN` defined: a half access with `addr[0]` ≠ 0, or a word access with `addr[1:0]` ≠ 0, returns `rsp_err` with no memory access.
- `DM_BRIDGE_ALIGN_CHECK_EN` undefined: misaligned low address bits are forced to the natural alignment (half clears bit 0, word clears bits 1:0) and the access proceeds normally.

## Structure
- Package `dm_bridge_pkg` holds:
  - size encodings `SZ_BYTE`/`SZ_HALF`/`SZ_WORD`
  - the state enum
  - `DM_WORDS_DEFAULT` = 4096
- Sub-module `dm_lane_align` is purely combinational. It provides load extract/extend and store merge from `size`, `signed`, `addr[1:0]`, `word` and `wdata`.

## Test plan
- Word store 0xDEADBEEF at 0x10, then word load 0x10 → store `rsp_valid` 2 cycles after accept; load returns 0xDEADBEEF 2 cycles after accept.
- Byte store 0xAA at 0x11 over 0x11223344 → 3-cycle latency; a subsequent word load returns 0x1122AA44. A signed byte load at 0x11 returns 0xFFFFFFAA; an unsigned one returns 0x000000AA.
- Half store 0x8001 at 0x12 over 0 → a signed half load at 0x12 returns 0xFFFF8001; a word load returns 0x80010000.
- Word load at byte address 0x4000 (index 4096) → `rsp_err` = 1 in cycle 1; `mem_wea` stays 0 throughout.
- Half load at 0x13:
  - with `DM_BRIDGE_ALIGN_CHECK_EN`: `rsp_err` = 1 and no write.
  - without it: reads lane 1 (bits 31:16).
- Assert `rsta_n` during WR of a sub-word store → `mem_wea` goes to 0 without a clock edge, the memory word is unchanged, no `rsp_valid` appears, and `req_ready` = 1.
